// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - matrix keypad model answering column scans with timed key presses
//
// Emulates one key switch per press command: the contact closes for HOLD_CYCLES,
// then opens for RELEASE_CYCLES, after which the next command may be accepted.
// Optional feature macro: KEYPAD_BOUNCE_EN adds contact chatter at each edge.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   cols       column drive from the keypad controller (one-hot, active-high)
//   rows       row sense back to the controller (active-high, combinational from cols)
//   key_valid  press command valid
//   key_code   key index = row*cols_count + col
//   key_ready  command can be accepted (IDLE only)
//   busy       press or release in progress
//   press_done one-cycle pulse on the last release cycle
//   scan_seen  pressed column was driven while the contact was closed
module keypad_emulator #(
    parameter int cols_count     = 4,
    parameter int rows_count     = 4,
    parameter int HOLD_CYCLES    = 64,
    parameter int RELEASE_CYCLES = 64,
    parameter int BOUNCE_CYCLES  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [cols_count-1:0] cols,
    output logic [rows_count-1:0] rows,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    output logic                  key_ready,
    output logic                  busy,
    output logic                  press_done,
    output logic                  scan_seen
);

    localparam int HR_MAX  = (HOLD_CYCLES > RELEASE_CYCLES) ? HOLD_CYCLES : RELEASE_CYCLES;
    localparam int CNT_MAX = (HR_MAX > BOUNCE_CYCLES) ? HR_MAX : BOUNCE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REL_LAST  = CW'(RELEASE_CYCLES - 1);
    // Second-to-last release count; unreachable when RELEASE_CYCLES == 1.
    localparam logic [CW-1:0] REL_PRE   = CW'(RELEASE_CYCLES - 2);
    localparam logic [4:0]    KEY_COUNT = 5'(rows_count * cols_count);
    localparam logic [4:0]    COLS_W    = 5'(cols_count);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESS   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [3:0]      code_q;

    logic [4:0]      code_ext;
    logic [4:0]      lat_row;
    logic [4:0]      lat_col;
    logic            code_ok;
    logic            contact;
    logic            col_hit;
    logic            hit;

    assign code_ext = {1'b0, code_q};
    assign lat_row  = code_ext / COLS_W;
    assign lat_col  = code_ext % COLS_W;
    assign code_ok  = (code_ext < KEY_COUNT);

`ifdef KEYPAD_BOUNCE_EN
    localparam logic [CW-1:0] BOUNCE_N = CW'(BOUNCE_CYCLES);

    // Chatter: PRESS starts closed, RELEASE starts open, toggling each cycle.
    always_comb begin
        contact = 1'b0;
        if (state == S_PRESS)
            contact = (count < BOUNCE_N) ? ~count[0] : 1'b1;
        else if (state == S_RELEASE)
            contact = (count < BOUNCE_N) ? count[0] : 1'b0;
    end
`else
    always_comb begin
        contact = (state == S_PRESS);
    end
`endif

    // Only the latched column bit matters, so non-one-hot drive is tolerated.
    always_comb begin
        col_hit = 1'b0;
        for (int c = 0; c < cols_count; c++) begin
            if (lat_col == 5'(c))
                col_hit = cols[c];
        end
    end

    assign hit = contact && code_ok && col_hit;

    // Zero-cycle path from cols to rows, as a physical switch would behave.
    always_comb begin
        rows = '0;
        for (int r = 0; r < rows_count; r++) begin
            if (lat_row == 5'(r))
                rows[r] = hit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            count      <= '0;
            code_q     <= 4'd0;
            key_ready  <= 1'b1;
            busy       <= 1'b0;
            press_done <= 1'b0;
            scan_seen  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    press_done <= 1'b0;
                    if (key_valid) begin
                        state     <= S_PRESS;
                        code_q    <= key_code;
                        count     <= '0;
                        scan_seen <= 1'b0;
                        key_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_PRESS: begin
                    scan_seen <= scan_seen | hit;
                    if (count == HOLD_LAST) begin
                        state      <= S_RELEASE;
                        count      <= '0;
                        press_done <= (RELEASE_CYCLES == 1);
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                S_RELEASE: begin
                    scan_seen <= scan_seen | hit;
                    if (count == REL_LAST) begin
                        // Pulse has already been shown; return to IDLE after it.
                        state      <= S_IDLE;
                        count      <= '0;
                        press_done <= 1'b0;
                        key_ready  <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        count      <= count + CW'(1);
                        press_done <= (count == REL_PRE);
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    count     <= '0;
                    key_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// tb/tb_keypad_emulator.sv - self-checking bench for keypad_emulator
module tb_keypad_emulator;

    localparam int C    = 4;
    localparam int R    = 4;
    localparam int HOLD = 64;
    localparam int REL  = 64;
    localparam int BNC  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] cols;
    logic [3:0] rows;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic       busy;
    logic       press_done;
    logic       scan_seen;

    int total = 0;
    int bad   = 0;

    // Reference model: cycles elapsed since accept (0 = idle), latched code, sticky flag.
    int m_t    = 0;
    int m_code = 0;
    bit m_seen = 1'b0;

    logic [3:0] s_rows;
    logic       s_ready, s_busy, s_pd, s_ss;

    typedef struct {
        logic [3:0] cols;
        logic [3:0] exp_rows;
        logic       exp_busy;
    } vec_t;
    vec_t tab [8];

    keypad_emulator #(
        .cols_count(C), .rows_count(R), .HOLD_CYCLES(HOLD),
        .RELEASE_CYCLES(REL), .BOUNCE_CYCLES(BNC)
    ) dut (
        .clk(clk), .rst(rst), .cols(cols), .rows(rows),
        .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
        .busy(busy), .press_done(press_done), .scan_seen(scan_seen)
    );

    always #5 clk = ~clk;

    function automatic bit m_contact(int t);
        if (t >= 1 && t <= HOLD) begin
`ifdef KEYPAD_BOUNCE_EN
            if (t <= BNC) return ((t - 1) % 2) == 0;
`endif
            return 1'b1;
        end
        if (t > HOLD && t <= HOLD + REL) begin
`ifdef KEYPAD_BOUNCE_EN
            if (t - HOLD <= BNC) return ((t - HOLD - 1) % 2) == 1;
`endif
            return 1'b0;
        end
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_rows(int t, int code, logic [3:0] c);
        logic [3:0] r;
        r = 4'd0;
        if (m_contact(t) && code < R * C && c[code % C])
            r[code / C] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, sample and compare against the model, then advance the model.
    task automatic step(input logic [3:0] c, input logic v, input logic [3:0] k);
        logic [3:0] er;
        @(negedge clk);
        cols = c; key_valid = v; key_code = k;
        #1;
        er = m_rows(m_t, m_code, c);
        s_rows = rows; s_ready = key_ready; s_busy = busy; s_pd = press_done; s_ss = scan_seen;
        chk("rows", int'(rows), int'(er));
        chk("key_ready", int'(key_ready), int'(m_t == 0));
        chk("busy", int'(busy), int'(m_t != 0));
        chk("press_done", int'(press_done), int'(m_t == HOLD + REL));
        chk("scan_seen", int'(scan_seen), int'(m_seen));
        @(posedge clk);
        if (m_t == 0) begin
            if (v) begin
                m_t = 1; m_code = int'(k); m_seen = 1'b0;
            end
        end else begin
            if (er != 4'd0) m_seen = 1'b1;
            m_t = (m_t == HOLD + REL) ? 0 : m_t + 1;
        end
    endtask

    task automatic accept(input int code, input logic [3:0] c);
        int g;
        g = 0;
        do begin
            step(c, 1'b1, 4'(code));
            g++;
        end while (m_t != 1 && g < 300);
        if (m_t != 1) chk("accept_timeout", 0, 1);
    endtask

    function automatic logic [3:0] col_pick(int mode, logic [3:0] cval, int i);
        if (mode == 0) return 4'b0001 << (i % 4);
        if (mode == 1) return cval;
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic wait_done(input int code, input int mode, input logic [3:0] cval,
                             input int inject, input int lat0,
                             output int lat, output bit seen);
        logic v;
        lat = lat0; seen = 1'b0; s_pd = 1'b0;
        while (!s_pd && lat < 400) begin
            v = (inject != 0 && lat + 1 == inject);
            step(col_pick(mode, cval, lat), v, 4'(code) ^ 4'hA);
            lat++;
            if (s_pd) seen = s_ss;
        end
        if (!s_pd) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int lat;
        bit seen;
        int npd;
        logic [9:0] ep, erl;
        logic [127:0] pv;

        tab[0] = '{4'b0001, 4'b0000, 1'b1};
        tab[1] = '{4'b0010, 4'b0000, 1'b1};
        tab[2] = '{4'b0100, 4'b0010, 1'b1};
        tab[3] = '{4'b1000, 4'b0000, 1'b1};
        tab[4] = '{4'b0110, 4'b0010, 1'b1};
        tab[5] = '{4'b1111, 4'b0010, 1'b1};
        tab[6] = '{4'b0000, 4'b0000, 1'b1};
        tab[7] = '{4'b1011, 4'b0000, 1'b1};

`ifdef KEYPAD_BOUNCE_EN
        ep  = 10'b11_0101_0101;
        erl = 10'b00_1010_1010;
`else
        ep  = 10'h3FF;
        erl = 10'h000;
`endif

        // Reset with all columns driven.
        cols = 4'b1111; key_valid = 1'b0; key_code = 4'd0;
        #1 rst = 1'b0;
        #2;
        chk("rst_rows", int'(rows), 0);
        chk("rst_ready", int'(key_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pd", int'(press_done), 0);
        chk("rst_ss", int'(scan_seen), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_rows", int'(rows), 0);
        chk("post_rst_ready", int'(key_ready), 1);
        chk("post_rst_busy", int'(busy), 0);

        // Code 6 (row1,col2): table of column patterns, then one-hot scanning.
        accept(6, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            step(tab[i].cols, 1'b0, 4'd6);
            chk("tab_rows", int'(s_rows), int'(tab[i].exp_rows));
            chk("tab_busy", int'(s_busy), int'(tab[i].exp_busy));
        end
        wait_done(6, 0, 4'b0000, 0, 8, lat, seen);
        chk("code6_latency", lat, HOLD + REL);
        chk("code6_seen", int'(seen), 1);

        // Code 5 with only column 0 driven; a second command while busy is ignored.
        accept(5, 4'b0001);
        wait_done(5, 1, 4'b0001, 20, 0, lat, seen);
        chk("code5_latency", lat, HOLD + REL);
        chk("code5_seen", int'(seen), 0);
        npd = 0;
        for (int i = 0; i < 140; i++) begin
            step(4'b0001, 1'b0, 4'd0);
            if (s_pd) npd++;
        end
        chk("code5_extra_done", npd, 0);

        // Code 15, then asynchronous reset mid-press.
        accept(15, 4'b1000);
        for (int i = 0; i < 10; i++) step(4'b1000, 1'b0, 4'd15);
        chk("code15_rows", int'(s_rows), 4'b1000);
        @(negedge clk);
        #2;
        key_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("async_rst_rows", int'(rows), 0);
        chk("async_rst_ready", int'(key_ready), 1);
        chk("async_rst_busy", int'(busy), 0);
        m_t = 0; m_code = 0; m_seen = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        accept(9, 4'b0010);
        wait_done(9, 1, 4'b0010, 0, 0, lat, seen);
        chk("after_rst_latency", lat, HOLD + REL);
        chk("after_rst_seen", int'(seen), 1);

        // Code 3, column 3 held: contact shape at both edges.
        accept(3, 4'b1000);
        pv = '0;
        for (int k = 1; k <= HOLD + REL; k++) begin
            step(4'b1000, 1'b0, 4'd3);
            pv[k-1] = s_rows[0];
        end
        for (int i = 0; i < 10; i++) begin
            chk("edge_press_row0", int'(pv[i]), int'(ep[i]));
            chk("edge_rel_row0", int'(pv[HOLD+i]), int'(erl[i]));
        end
        chk("edge_done", int'(s_pd), 1);

        // Back-to-back with key_valid held high: codes 0 then 1.
        accept(0, 4'b0011);
        lat = 0; s_pd = 1'b0;
        while (!s_pd && lat < 400) begin
            step(4'b0011, 1'b1, 4'd0);
            lat++;
        end
        chk("b2b_first_latency", lat, HOLD + REL);
        chk("b2b_first_seen", int'(s_ss), 1);
        step(4'b0011, 1'b1, 4'd1);
        chk("b2b_ready_after_done", int'(s_ready), 1);
        step(4'b0011, 1'b0, 4'd1);
        chk("b2b_second_busy", int'(s_busy), 1);
        wait_done(1, 1, 4'b0011, 0, 1, lat, seen);
        chk("b2b_second_latency", lat, HOLD + REL);
        chk("b2b_second_seen", int'(seen), 1);
        for (int i = 0; i < 4; i++) step(4'b0011, 1'b0, 4'd0);
        chk("b2b_idle", int'(s_busy), 0);

        // Randomized commands, columns and busy-time noise.
        for (int n = 0; n < 20; n++) begin
            accept(int'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            wait_done(m_code, 2, 4'b0000, int'($urandom_range(0, 120)), 0, lat, seen);
            chk("rand_latency", lat, HOLD + REL);
            for (int i = 0; i < int'($urandom_range(0, 3)); i++)
                step(4'($urandom_range(0, 15)), 1'b0, 4'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
